// File: rtl/pellet_controller.sv
// Pellet bookkeeping, scoring and fright-window producer for the power_pellet link.
// Optional extra-life pulse is built only when PELLET_EXTRA_LIFE_EN is defined.
module pellet_controller #(
  parameter int                      IDX_W          = 6,
  parameter int                      N_PELLETS      = 64,
  parameter logic [(2**IDX_W)-1:0]   POWER_MASK     = 64'h8100_0000_0000_0081,
  parameter int                      FRIGHT_CYCLES  = 16,
  parameter int                      SCORE_W        = 16,
  parameter int                      PELLET_PTS     = 10,
  parameter int                      POWER_PTS      = 50,
  parameter int                      EXTRA_LIFE_PTS = 10000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               eat_valid,
  input  logic [IDX_W-1:0]   eat_idx,
  output logic               eat_ready,
  input  logic               ghost_eaten,
  output logic               power_pellet,
  output logic               fright_active,
  output logic [SCORE_W-1:0] score,
  output logic [IDX_W:0]     pellets_left,
  output logic               level_clear,
  output logic               extra_life
);

  localparam int CELLS   = 2**IDX_W;
  localparam int TMR_W   = $clog2(FRIGHT_CYCLES + 1);
  localparam int CHAIN_W = 11;
  localparam int SUM_W   = SCORE_W + 12;

  localparam logic [IDX_W:0]       N_P       = (IDX_W+1)'(N_PELLETS);
  localparam logic [CELLS-1:0]     FULL_MAP  = {CELLS{1'b1}} >> (CELLS - N_PELLETS);
  localparam logic [TMR_W-1:0]     FRIGHT_LD = TMR_W'(FRIGHT_CYCLES);
  localparam logic [CHAIN_W-1:0]   CHAIN_MIN = CHAIN_W'(200);
  localparam logic [CHAIN_W-1:0]   CHAIN_MAX = CHAIN_W'(1600);
  localparam logic [SUM_W-1:0]     SCORE_MAX = SUM_W'((2**SCORE_W) - 1);

  if (N_PELLETS > CELLS) begin : g_bad_cells
    $error("N_PELLETS does not fit in IDX_W");
  end
  if (EXTRA_LIFE_PTS >= 2**SCORE_W) begin : g_bad_thr
    $error("EXTRA_LIFE_PTS exceeds score range");
  end

  typedef enum logic [1:0] {S_IDLE, S_PLAY, S_CLEAR} state_t;

  state_t             r_state, w_state_next;
  logic [CELLS-1:0]   r_bitmap, w_bitmap_next;
  logic [IDX_W:0]     r_left, w_left_next;
  logic [TMR_W-1:0]   r_timer, w_timer_next;
  logic [CHAIN_W-1:0] r_chain, w_chain_next;
  logic [CHAIN_W:0]   w_chain_dbl;
  logic [SCORE_W-1:0] r_score, w_score_next;
  logic [SUM_W-1:0]   w_add, w_sum;
  logic               r_eat_ready, r_power, r_fright, r_clear;
  logic               w_hit, w_power, w_ghost, w_clear_pulse;

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  assign w_chain_dbl = {r_chain, 1'b0};

  // NOTE: every signal gets a default before the case so no path can infer a latch.
  always_comb begin
    w_state_next  = r_state;
    w_bitmap_next = r_bitmap;
    w_left_next   = r_left;
    w_chain_next  = r_chain;
    w_timer_next  = (r_timer != '0) ? r_timer - TMR_W'(1) : '0;
    w_hit         = 1'b0;
    w_power       = 1'b0;
    w_ghost       = 1'b0;
    w_clear_pulse = 1'b0;
    w_add         = '0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_bitmap_next = FULL_MAP;
          w_left_next   = N_P;
          w_state_next  = S_PLAY;
        end
      end
      S_PLAY: begin
        w_hit   = eat_valid && ({1'b0, eat_idx} < N_P) && r_bitmap[eat_idx];
        w_ghost = ghost_eaten && r_fright;
        if (w_hit) begin
          w_bitmap_next[eat_idx] = 1'b0;
          w_left_next            = r_left - (IDX_W+1)'(1);
          w_power                = POWER_MASK[eat_idx];
          w_add                  = w_power ? SUM_W'(POWER_PTS) : SUM_W'(PELLET_PTS);
        end
        if (w_ghost) begin
          w_add        = w_add + SUM_W'(r_chain);
          w_chain_next = (w_chain_dbl > {1'b0, CHAIN_MAX}) ? CHAIN_MAX : w_chain_dbl[CHAIN_W-1:0];
        end
        // A power pellet in the same cycle as a ghost still wins the chain reset.
        if (w_power) begin
          w_chain_next = CHAIN_MIN;
          w_timer_next = FRIGHT_LD;
        end
        if (w_hit && (r_left == (IDX_W+1)'(1))) begin
          w_state_next  = S_CLEAR;
          w_clear_pulse = 1'b1;
        end
      end
      S_CLEAR: begin
        w_timer_next = '0;
        w_chain_next = CHAIN_MIN;
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  assign w_sum        = SUM_W'(r_score) + w_add;
  assign w_score_next = (w_sum > SCORE_MAX) ? SCORE_MAX[SCORE_W-1:0] : w_sum[SCORE_W-1:0];

  // NOTE: the bitmap is a plain register vector, so it is cleared on reset like any other state.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_bitmap    <= '0;
      r_left      <= '0;
      r_timer     <= '0;
      r_chain     <= CHAIN_MIN;
      r_score     <= '0;
      r_eat_ready <= 1'b0;
      r_power     <= 1'b0;
      r_fright    <= 1'b0;
      r_clear     <= 1'b0;
    end else begin
      r_bitmap    <= w_bitmap_next;
      r_left      <= w_left_next;
      r_timer     <= w_timer_next;
      r_chain     <= w_chain_next;
      r_score     <= w_score_next;
      r_eat_ready <= (w_state_next == S_PLAY);
      r_power     <= w_power;
      r_fright    <= (w_timer_next != '0);
      r_clear     <= w_clear_pulse;
    end
  end

`ifdef PELLET_EXTRA_LIFE_EN
  localparam logic [SUM_W-1:0] LIFE_THR = SUM_W'(EXTRA_LIFE_PTS);
  logic r_life_given, r_extra_life, w_life_hit;

  assign w_life_hit = !r_life_given && (SUM_W'(r_score) < LIFE_THR)
                      && (SUM_W'(w_score_next) >= LIFE_THR);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_life_given <= 1'b0;
      r_extra_life <= 1'b0;
    end else begin
      r_extra_life <= w_life_hit;
      if (w_life_hit) r_life_given <= 1'b1;
    end
  end

  assign extra_life = r_extra_life;
`else
  assign extra_life = 1'b0;
`endif

  assign eat_ready     = r_eat_ready;
  assign power_pellet  = r_power;
  assign fright_active = r_fright;
  assign score         = r_score;
  assign pellets_left  = r_left;
  assign level_clear   = r_clear;

endmodule

// File: tb/tb_pellet_controller.sv
// Directed + randomized bench for pellet_controller against an integer-level reference model.
module tb_pellet_controller;

  localparam int N   = 64;
  localparam int THR = 100;

  logic        clk = 1'b0;
  logic        reset, start, eat_valid, ghost_eaten;
  logic [5:0]  eat_idx;
  logic        eat_ready, power_pellet, fright_active, level_clear, extra_life;
  logic [15:0] score;
  logic [6:0]  pellets_left;

  logic        b_reset, b_start, b_eat_valid, b_ghost_eaten;
  logic [5:0]  b_eat_idx;
  logic        b_eat_ready, b_power_pellet, b_fright_active, b_level_clear, b_extra_life;
  logic [15:0] b_score;
  logic [6:0]  b_pellets_left;

  always #5 clk = ~clk;

  pellet_controller #(.EXTRA_LIFE_PTS(THR)) u_dut (
    .clk(clk), .reset(reset), .start(start), .eat_valid(eat_valid), .eat_idx(eat_idx),
    .eat_ready(eat_ready), .ghost_eaten(ghost_eaten), .power_pellet(power_pellet),
    .fright_active(fright_active), .score(score), .pellets_left(pellets_left),
    .level_clear(level_clear), .extra_life(extra_life)
  );

  pellet_controller #(.N_PELLETS(60)) u_dut60 (
    .clk(clk), .reset(b_reset), .start(b_start), .eat_valid(b_eat_valid), .eat_idx(b_eat_idx),
    .eat_ready(b_eat_ready), .ghost_eaten(b_ghost_eaten), .power_pellet(b_power_pellet),
    .fright_active(b_fright_active), .score(b_score), .pellets_left(b_pellets_left),
    .level_clear(b_level_clear), .extra_life(b_extra_life)
  );

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s at %0t: got %0d, expected %0d", tag, $time, got, exp);
  endtask

  // Reference model: modes 0=idle 1=play 2=clear, everything else plain integers.
  int  m_mode, m_left, m_score, m_chain, m_timer;
  bit  m_has[N];
  bit  m_life;
  bit  e_ready, e_pp, e_fa, e_lc, e_el;

  function automatic bit is_power(input int i);
    return (i == 0) || (i == 7) || (i == 56) || (i == 63);
  endfunction

  task automatic model_step(input bit rst, input bit st, input bit ev, input int idx, input bit ge);
    int add, old;
    bit pw;
    if (rst) begin
      m_mode = 0; m_left = 0; m_score = 0; m_chain = 200; m_timer = 0; m_life = 0;
      foreach (m_has[i]) m_has[i] = 1'b0;
      e_ready = 0; e_pp = 0; e_fa = 0; e_lc = 0; e_el = 0;
      return;
    end
    add = 0; pw = 0; e_pp = 0; e_lc = 0; e_el = 0;
    if (m_mode == 0) begin
      if (st) begin
        foreach (m_has[i]) m_has[i] = 1'b1;
        m_left = N;
        m_mode = 1;
      end
      if (m_timer > 0) m_timer--;
    end else if (m_mode == 1) begin
      if (ev && idx < N && m_has[idx]) begin
        m_has[idx] = 1'b0;
        m_left--;
        pw  = is_power(idx);
        add += pw ? 50 : 10;
      end
      if (ge && e_fa) begin
        add += m_chain;
        m_chain = (m_chain * 2 > 1600) ? 1600 : m_chain * 2;
      end
      if (pw) begin
        m_chain = 200; m_timer = 16; e_pp = 1;
      end else if (m_timer > 0) m_timer--;
      if (m_left == 0) begin
        m_mode = 2; e_lc = 1;
      end
    end else begin
      m_timer = 0; m_chain = 200; m_mode = 0;
    end
    old     = m_score;
    m_score = (old + add > 65535) ? 65535 : old + add;
`ifdef PELLET_EXTRA_LIFE_EN
    if (!m_life && old < THR && m_score >= THR) begin
      e_el = 1; m_life = 1;
    end
`endif
    e_fa    = (m_timer != 0);
    e_ready = (m_mode == 1);
  endtask

  task automatic step(input bit rst, input bit st, input bit ev, input int idx, input bit ge);
    reset = rst; start = st; eat_valid = ev; eat_idx = 6'(idx); ghost_eaten = ge;
    @(posedge clk);
    model_step(rst, st, ev, idx, ge);
    #1;
    check("eat_ready",     32'(eat_ready),     32'(e_ready));
    check("power_pellet",  32'(power_pellet),  32'(e_pp));
    check("fright_active", 32'(fright_active), 32'(e_fa));
    check("level_clear",   32'(level_clear),   32'(e_lc));
    check("extra_life",    32'(extra_life),    32'(e_el));
    check("score",         32'(score),         32'(m_score));
    check("pellets_left",  32'(pellets_left),  32'(m_left));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
  endtask

  task automatic step60(input bit rst, input bit st, input bit ev, input int idx);
    b_reset = rst; b_start = st; b_eat_valid = ev; b_eat_idx = 6'(idx); b_ghost_eaten = 1'b0;
    @(posedge clk);
    #1;
  endtask

  int score_before;
  int fright_len;

  initial begin
    b_reset = 1; b_start = 0; b_eat_valid = 0; b_eat_idx = '0; b_ghost_eaten = 0;

    step(1, 0, 0, 0, 0);
    step(1, 1, 1, 3, 1);
    check("rst_score", 32'(score), 0);
    check("rst_left",  32'(pellets_left), 0);
    idle(1);

    step(0, 1, 0, 0, 0);
    step(0, 0, 1, 5, 0);
    check("eat5_score", 32'(score), 10);
    check("eat5_left",  32'(pellets_left), 63);
    step(0, 0, 1, 5, 0);
    check("reeat5_score", 32'(score), 10);

    step(0, 0, 1, 0, 0);
    check("power0_score", 32'(score), 60);
    fright_len = 1;
    for (int i = 0; i < 9; i++) begin
      step(0, 0, 0, 0, 0);
      if (fright_active) fright_len++;
    end
    step(0, 0, 1, 7, 0);
    fright_len = 1;
    for (int i = 0; i < 20; i++) begin
      step(0, 0, 0, 0, 0);
      if (fright_active) fright_len++;
    end
    check("fright_len", 32'(fright_len), 16);

    step(0, 0, 1, 56, 0);
    score_before = m_score;
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 1);
    check("chain_sum", 32'(score), 32'(score_before + 200 + 400 + 800 + 1600 + 1600));
    idle(20);
    step(0, 0, 0, 0, 1);
    check("ghost_no_fright", 32'(score), 32'(score_before + 4600));
    step(0, 0, 1, 63, 0);
    step(0, 0, 0, 0, 1);
    check("chain_reset", 32'(score), 32'(score_before + 4600 + 50 + 200));

    for (int i = 0; i < N; i++) step(0, 0, 1, i, 0);
    idle(3);
    check("clear_idle_ready", 32'(eat_ready), 0);

    score_before = m_score;
    step(0, 1, 0, 0, 0);
    check("restart_left", 32'(pellets_left), 64);
    for (int i = N - 1; i >= 0; i--) step(0, 0, 1, i, 0);
    idle(2);
    check("level_800", 32'(score), 32'(score_before + 800));

    step(0, 1, 0, 0, 0);
    step(0, 0, 1, 63, 0);
    idle(3);
    step(1, 0, 0, 0, 0);
    check("midfright_rst_score",  32'(score), 0);
    check("midfright_rst_fright", 32'(fright_active), 0);
    idle(2);

    for (int c = 0; c < 6000; c++) begin
      step(($urandom_range(0, 2999) == 0), ($urandom_range(0, 19) == 0),
           ($urandom_range(0, 9) < 7), int'($urandom_range(0, 63)), $urandom_range(0, 1) == 1);
    end
    check("random_saturated", 32'(score == 16'hFFFF), 32'(m_score == 65535));

    step60(1, 0, 0, 0);
    step60(0, 1, 0, 0);
    check("n60_start_left", 32'(b_pellets_left), 60);
    step60(0, 0, 1, 62);
    check("n60_idx62_left",  32'(b_pellets_left), 60);
    check("n60_idx62_score", 32'(b_score), 0);
    step60(0, 0, 1, 60);
    check("n60_idx60_left", 32'(b_pellets_left), 60);
    step60(0, 0, 1, 59);
    check("n60_idx59_score", 32'(b_score), 10);
    step60(0, 0, 1, 0);
    check("n60_power_pulse", 32'(b_power_pellet), 1);
    check("n60_power_score", 32'(b_score), 60);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
